gate_fire_scheduler: RTL and testbench

//   Shares one gate-output wire driver between GATE_COUNT logic gates during a logic frame.

---
 rtl/gate_fire_scheduler.sv | 149 ++++++++++++++
 tb/tb_gate_fire_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_fire_scheduler.sv
// Round-robin, one-shot-per-frame fire arbiter feeding a single gate-output wire driver.
// Optional stall watchdog: define GATE_SCHED_WATCHDOG_EN to build it.
module gate_fire_scheduler #(
    parameter  int unsigned GATE_COUNT      = 8,
    parameter  int unsigned WATCHDOG_CYCLES = 255,
    localparam int unsigned ID_W            = $clog2(GATE_COUNT)
) (
    input  logic                  clk,
    input  logic                  logic_reset,
    input  logic                  frame_start,
    input  logic [GATE_COUNT-1:0] req,
    output logic                  fire_valid,
    output logic [ID_W-1:0]       fire_id,
    input  logic                  fire_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [7:0]            drop_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [GATE_COUNT-1:0] pending, fired_mask, hs_mask, eff_mask, new_req;
    logic [ID_W-1:0]       rr_ptr, pick_id, next_ptr;
    logic                  pick_found, handshake, end_cond, wd_trip;
    logic [7:0]            drop_nxt;
    int unsigned           scan_idx, drop_sum;

    if (GATE_COUNT < 2 || WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 65535) begin : g_param_check
        $error("gate_fire_scheduler: parameter out of range");
    end

    assign handshake  = fire_valid && fire_ready;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // The gate being accepted this cycle counts as already fired, so its
    // same-cycle request is dropped and counted rather than re-queued.
    always_comb begin
        hs_mask = '0;
        if (handshake) hs_mask[fire_id] = 1'b1;
        eff_mask = fired_mask | hs_mask;
        new_req  = req & ~eff_mask;
    end

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int unsigned i = 0; i < GATE_COUNT; i++) begin
            scan_idx = i + 32'(rr_ptr);
            if (scan_idx >= GATE_COUNT) scan_idx = scan_idx - GATE_COUNT;
            if (!pick_found && pending[ID_W'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        drop_sum = 32'(drop_count);
        for (int unsigned i = 0; i < GATE_COUNT; i++) begin
            if (req[i] && eff_mask[i]) drop_sum = drop_sum + 1;
        end
        drop_nxt = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
    end

    assign next_ptr = (fire_id == ID_W'(GATE_COUNT - 1)) ? '0 : fire_id + 1'b1;
    assign end_cond = (pending == '0) && !fire_valid && ((req & ~fired_mask) == '0);

`ifdef GATE_SCHED_WATCHDOG_EN
    logic [15:0] stall_cnt;
    logic        abort_q;

    assign wd_trip = (state == RUN) && fire_valid && !fire_ready &&
                     (stall_cnt == 16'(WATCHDOG_CYCLES - 1));
    assign frame_abort = abort_q;

    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= wd_trip;
            if (state == IDLE && frame_start) stall_cnt <= '0;
            else if (handshake)               stall_cnt <= '0;
            else if (fire_valid && !fire_ready) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign wd_trip     = 1'b0;
    assign frame_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (wd_trip || end_cond) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            pending    <= '0;
            fired_mask <= '0;
            rr_ptr     <= '0;
            fire_valid <= 1'b0;
            fire_id    <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        pending    <= '0;
                        fired_mask <= '0;
                        drop_count <= '0;
                    end
                end
                RUN: begin
                    pending    <= (pending & ~hs_mask) | new_req;
                    fired_mask <= fired_mask | hs_mask;
                    drop_count <= drop_nxt;
                    if (handshake) begin
                        fire_valid <= 1'b0;
                        rr_ptr     <= next_ptr;
                    end else if (!fire_valid && pick_found) begin
                        fire_valid <= 1'b1;
                        fire_id    <= pick_id;
                    end
                    if (wd_trip) begin
                        pending    <= '0;
                        fire_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_fire_scheduler.sv
// Directed bench for gate_fire_scheduler; watchdog checks follow GATE_SCHED_WATCHDOG_EN.
module tb_gate_fire_scheduler;

    logic       clk;
    logic       logic_reset;
    logic       frame_start;
    logic [7:0] req;
    logic       fire_valid;
    logic [2:0] fire_id;
    logic       fire_ready;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned t2_ids [4] = '{0, 2, 5, 7};

    gate_fire_scheduler #(.GATE_COUNT(8), .WATCHDOG_CYCLES(16)) dut (
        .clk         (clk),
        .logic_reset (logic_reset),
        .frame_start (frame_start),
        .req         (req),
        .fire_valid  (fire_valid),
        .fire_id     (fire_id),
        .fire_ready  (fire_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic_reset = 1'b0;
        frame_start = 1'b0;
        req         = '0;
        fire_ready  = 1'b0;
        step();
        step();
        chk("reset_valid", 32'(fire_valid), 0);
        chk("reset_id", 32'(fire_id), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_abort", 32'(frame_abort), 0);
        chk("reset_drop", 32'(drop_count), 0);
        logic_reset = 1'b1;

        // requests while idle are ignored
        req = 8'hFF;
        step();
        step();
        chk("idle_no_offer", 32'(fire_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        req = '0;
        step();

        // order 0,2,5,7 with bubble; frame_start mid-frame is ignored
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t2_busy", 32'(busy), 1);
        chk("t2_no_offer_yet", 32'(fire_valid), 0);
        req = 8'hA5;
        fire_ready = 1'b1;
        step();
        req = '0;
        chk("t2_latency", 32'(fire_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_offer_valid", 32'(fire_valid), 1);
            chk("t2_offer_id", 32'(fire_id), t2_ids[k]);
            if (k == 1) frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            chk("t2_bubble", 32'(fire_valid), 0);
            chk("t2_no_early_done", 32'(frame_done), 0);
        end
        step();
        chk("t2_done", 32'(frame_done), 1);
        chk("t2_done_busy", 32'(busy), 1);
        step();
        chk("t2_done_pulse", 32'(frame_done), 0);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_drop", 32'(drop_count), 0);

        // rotation after gate 5, stall holds fire_id
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 8'h20;
        fire_ready = 1'b0;
        step();
        req = '0;
        step();
        chk("t3_valid5", 32'(fire_valid), 1);
        chk("t3_id5", 32'(fire_id), 5);
        fire_ready = 1'b1;
        step();
        chk("t3_hs5", 32'(fire_valid), 0);
        fire_ready = 1'b0;
        req = 8'h42;
        step();
        chk("t3_gap", 32'(fire_valid), 0);
        chk("t3_busy", 32'(busy), 1);
        req = '0;
        step();
        chk("t3_valid6", 32'(fire_valid), 1);
        chk("t3_id6", 32'(fire_id), 6);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t3_stall_valid", 32'(fire_valid), 1);
            chk("t3_stall_id", 32'(fire_id), 6);
        end
        fire_ready = 1'b1;
        step();
        chk("t3_hs6", 32'(fire_valid), 0);
        step();
        chk("t3_valid1", 32'(fire_valid), 1);
        chk("t3_id1", 32'(fire_id), 1);
        step();
        chk("t3_hs1", 32'(fire_valid), 0);
        step();
        chk("t3_done", 32'(frame_done), 1);
        step();
        chk("t3_idle", 32'(busy), 0);

        // one-shot drops and same-cycle handshake drop
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 8'h18;
        fire_ready = 1'b1;
        step();
        req = '0;
        step();
        chk("t4_id3", 32'(fire_id), 3);
        chk("t4_valid3", 32'(fire_valid), 1);
        step();
        chk("t4_hs3", 32'(fire_valid), 0);
        step();
        chk("t4_valid4", 32'(fire_valid), 1);
        chk("t4_id4", 32'(fire_id), 4);
        fire_ready = 1'b0;
        req = 8'h08;
        step();
        chk("t4_drop1", 32'(drop_count), 1);
        req = '0;
        step();
        req = 8'h08;
        step();
        chk("t4_drop2", 32'(drop_count), 2);
        chk("t4_no_refire", 32'(fire_id), 4);
        req = 8'h10;
        fire_ready = 1'b1;
        step();
        chk("t4_hs4", 32'(fire_valid), 0);
        chk("t4_same_cycle_drop", 32'(drop_count), 3);
        req = '0;
        step();
        chk("t4_done", 32'(frame_done), 1);
        step();
        chk("t4_idle", 32'(busy), 0);
        chk("t4_drop_hold", 32'(drop_count), 3);

`ifndef GATE_SCHED_WATCHDOG_EN
        // drop counter saturation
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("sat_cleared", 32'(drop_count), 0);
        req = 8'h03;
        fire_ready = 1'b1;
        step();
        req = '0;
        step();
        chk("sat_id0", 32'(fire_id), 0);
        step();
        step();
        chk("sat_id1", 32'(fire_id), 1);
        fire_ready = 1'b0;
        req = 8'h01;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 254) chk("sat_254", 32'(drop_count), 254);
        end
        chk("sat_255", 32'(drop_count), 255);
        req = '0;
        fire_ready = 1'b1;
        step();
        chk("sat_hs", 32'(fire_valid), 0);
        step();
        chk("sat_done", 32'(frame_done), 1);
        step();
`endif

        // stalled driver: watchdog abort or indefinite hold
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 8'h01;
        fire_ready = 1'b0;
        step();
        req = '0;
        step();
        chk("t6_valid", 32'(fire_valid), 1);
        chk("t6_id", 32'(fire_id), 0);
        for (int k = 0; k < 15; k++) step();
        chk("t6_no_done_yet", 32'(frame_done), 0);
        step();
`ifdef GATE_SCHED_WATCHDOG_EN
        chk("t6_wd_done", 32'(frame_done), 1);
        chk("t6_wd_abort", 32'(frame_abort), 1);
        chk("t6_wd_withdraw", 32'(fire_valid), 0);
        step();
        chk("t6_wd_idle", 32'(busy), 0);
        chk("t6_wd_abort_pulse", 32'(frame_abort), 0);
`else
        chk("t6_no_abort", 32'(frame_abort), 0);
        chk("t6_busy_holds", 32'(busy), 1);
        chk("t6_offer_holds", 32'(fire_valid), 1);
        chk("t6_no_done", 32'(frame_done), 0);
        fire_ready = 1'b1;
        step();
        step();
        chk("t6_done", 32'(frame_done), 1);
        step();
`endif

        // async reset while an offer is outstanding
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 8'h01;
        fire_ready = 1'b1;
        step();
        req = 8'h02;
        step();
        chk("t1_valid0", 32'(fire_valid), 1);
        chk("t1_id0", 32'(fire_id), 0);
        req = '0;
        step();
        chk("t1_hs0", 32'(fire_valid), 0);
        fire_ready = 1'b0;
        step();
        chk("t1_valid1", 32'(fire_valid), 1);
        chk("t1_id1", 32'(fire_id), 1);
        req = 8'h01;
        step();
        chk("t1_drop", 32'(drop_count), 1);
        req = '0;
        #2;
        logic_reset = 1'b0;
        #1;
        chk("t1_rst_valid", 32'(fire_valid), 0);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_drop", 32'(drop_count), 0);
        step();
        step();
        logic_reset = 1'b1;
        step();
        chk("t1_post_busy", 32'(busy), 0);
        chk("t1_post_valid", 32'(fire_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
